// File: rtl/mac_sum_pkg.sv
// ---------------------------------------------------------------------------
// mac_sum_pkg
//   Shared FIR output-stage definitions: data and adder widths, the signed
//   saturation limits and a helper that clamps a guard-extended sum back to
//   the output width.
// ---------------------------------------------------------------------------
package mac_sum_pkg;

    localparam int DATA_W  = 16;
    localparam int GUARD_W = 2;
    localparam int SUM_W   = DATA_W + GUARD_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam sample_t SAT_MAX = 16'sh7FFF;
    localparam sample_t SAT_MIN = 16'sh8000;

    // The limits are signed, so the size casts sign-extend them to the
    // guard width before comparing against the wide sum.
    function automatic sample_t saturate(input sum_t s);
        sample_t result;
        if (s > sum_t'(SAT_MAX)) begin
            result = SAT_MAX;
        end else if (s < sum_t'(SAT_MIN)) begin
            result = SAT_MIN;
        end else begin
            result = s[DATA_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/mac_sum_sat_add4.sv
// ---------------------------------------------------------------------------
// mac_sum_sat_add4
//   Purely combinational 4-input signed adder with saturation.
//   Ports:
//     iMac1..iMac4  in  DATA_W  signed partial MAC results
//     oSat          out DATA_W  sum clamped to the signed DATA_W range
// ---------------------------------------------------------------------------
module mac_sum_sat_add4
    import mac_sum_pkg::*;
(
    input  sample_t iMac1,
    input  sample_t iMac2,
    input  sample_t iMac3,
    input  sample_t iMac4,
    output sample_t oSat
);

    sum_t wSum;

    // Two guard bits are enough for four DATA_W operands, so the wide sum
    // itself can never wrap; only the narrowing back to DATA_W needs clamping.
    always_comb begin
        wSum = sum_t'(iMac1) + sum_t'(iMac2) + sum_t'(iMac3) + sum_t'(iMac4);
        oSat = saturate(wSum);
    end

endmodule

// File: rtl/mac_sum.sv
// ---------------------------------------------------------------------------
// mac_sum
//   Final output stage of the 4-way parallel FIR filter. Adds the four
//   signed MAC partial sums with saturation, captures the result in a delay
//   register on iEnDelay and moves it to the output on the sample strobe.
//   Ports:
//     iClk12M        in   1       12 MHz system clock, rising edge
//     iRsn           in   1       asynchronous active-low reset
//     iEnSample600k  in   1       loads oFirOut from the delay register
//     iEnDelay       in   1       loads the delay register from the sum
//     iMac1..iMac4   in   DATA_W  signed partial sums from the MAC slices
//     oFirOut        out  DATA_W  registered signed filter output
// ---------------------------------------------------------------------------
module mac_sum
    import mac_sum_pkg::*;
(
    input  logic    iClk12M,
    input  logic    iRsn,
    input  logic    iEnSample600k,
    input  logic    iEnDelay,
    input  sample_t iMac1,
    input  sample_t iMac2,
    input  sample_t iMac3,
    input  sample_t iMac4,
    output sample_t oFirOut
);

    sample_t wSat;
    sample_t rFinalSumDelay;

    mac_sum_sat_add4 uSatAdd4 (
        .iMac1 (iMac1),
        .iMac2 (iMac2),
        .iMac3 (iMac3),
        .iMac4 (iMac4),
        .oSat  (wSat)
    );

    // Two independently enabled stages. When both enables fire on the same
    // edge the output takes the delay value from before that edge, giving a
    // clean two-stage pipeline.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            rFinalSumDelay <= '0;
            oFirOut        <= '0;
        end else begin
            if (iEnDelay) begin
                rFinalSumDelay <= wSat;
            end
            if (iEnSample600k) begin
                oFirOut <= rFinalSumDelay;
            end
        end
    end

endmodule

// File: tb/tb_mac_sum.sv
// ---------------------------------------------------------------------------
// tb_mac_sum
//   Self-checking bench for mac_sum: directed scenarios followed by random
//   traffic, all compared against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mac_sum;

    logic               clock;
    logic               iRsn;
    logic               iEnSample600k;
    logic               iEnDelay;
    logic signed [15:0] iMac1;
    logic signed [15:0] iMac2;
    logic signed [15:0] iMac3;
    logic signed [15:0] iMac4;
    logic signed [15:0] oFirOut;

    int assertCount;
    int failCount;

    // Reference model state: the value held in each register stage.
    logic [15:0] refDelay;
    logic [15:0] refOut;

    mac_sum dut (
        .iClk12M       (clock),
        .iRsn          (iRsn),
        .iEnSample600k (iEnSample600k),
        .iEnDelay      (iEnDelay),
        .iMac1         (iMac1),
        .iMac2         (iMac2),
        .iMac3         (iMac3),
        .iMac4         (iMac4),
        .oFirOut       (oFirOut)
    );

    // 12 MHz-ish clock; exact period is irrelevant to the logic.
    initial clock = 1'b0;
    always #42 clock = ~clock;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Clamp an exact integer sum to the signed 16-bit range.
    function automatic logic [15:0] refSat(input int s);
        logic [15:0] r;
        if (s > 32767) begin
            r = 16'h7FFF;
        end else if (s < -32768) begin
            r = 16'h8000;
        end else begin
            r = s[15:0];
        end
        return r;
    endfunction

    // Drive one clock's worth of inputs, advance the model for that edge,
    // then compare both register stages just after the edge.
    task automatic applyStimulus(input logic signed [15:0] m1, input logic signed [15:0] m2,
                                 input logic signed [15:0] m3, input logic signed [15:0] m4,
                                 input logic enD, input logic enS, input string tag);
        int          s;
        logic [15:0] nextDelay;
        logic [15:0] nextOut;
        iMac1         = m1;
        iMac2         = m2;
        iMac3         = m3;
        iMac4         = m4;
        iEnDelay      = enD;
        iEnSample600k = enS;
        s = int'(m1) + int'(m2) + int'(m3) + int'(m4);
        nextDelay = enD ? refSat(s) : refDelay;
        nextOut   = enS ? refDelay : refOut;
        @(posedge clock);
        #1;
        refDelay = nextDelay;
        refOut   = nextOut;
        checkOutput({tag, ".out"},   oFirOut,            refOut);
        checkOutput({tag, ".delay"}, dut.rFinalSumDelay, refDelay);
    endtask

    function automatic logic signed [15:0] randSample();
        logic signed [15:0] v;
        case ($urandom_range(3, 0))
            0:       v = 16'sh7FFF;
            1:       v = 16'sh8000;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        assertCount = 0;
        failCount   = 0;

        // Reset asserted with busy inputs and both enables high.
        iRsn          = 1'b0;
        iMac1         = 16'sd1000;
        iMac2         = 16'sd2000;
        iMac3         = 16'sd3000;
        iMac4         = 16'sd4000;
        iEnDelay      = 1'b1;
        iEnSample600k = 1'b1;
        refDelay      = 16'h0000;
        refOut        = 16'h0000;
        #1;
        checkOutput("reset.immediate.out",   oFirOut,            16'h0000);
        checkOutput("reset.immediate.delay", dut.rFinalSumDelay, 16'h0000);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset.held.out",   oFirOut,            16'h0000);
        checkOutput("reset.held.delay", dut.rFinalSumDelay, 16'h0000);

        // Release reset away from the rising edge with enables idle.
        iEnDelay      = 1'b0;
        iEnSample600k = 1'b0;
        @(negedge clock);
        iRsn = 1'b1;
        applyStimulus(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 1'b0, 1'b0, "reset.idle");

        // Delay accumulation: sums 160, 224, 288, 352, 416.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(16'(16 + 16*k), 16'(32 + 16*k), 16'(48 + 16*k), 16'(64 + 16*k),
                          1'b1, 1'b0, $sformatf("accum%0d", k));
        end
        checkOutput("accum.final", dut.rFinalSumDelay, 16'd416);

        // Sampling with both enables: first edge emits 416, then 480 onward.
        applyStimulus(16'sd96, 16'sd112, 16'sd128, 16'sd144, 1'b1, 1'b1, "sample.edge1");
        checkOutput("sample.edge1.out416", oFirOut, 16'd416);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'sd96, 16'sd112, 16'sd128, 16'sd144, 1'b1, 1'b1,
                          $sformatf("sample.edge%0d", k + 2));
        end
        checkOutput("sample.out480", oFirOut, 16'h01E0);

        // Hold: enables low, inputs wander.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(randSample(), randSample(), randSample(), randSample(),
                          1'b0, 1'b0, $sformatf("hold%0d", k));
        end
        checkOutput("hold.out480", oFirOut, 16'h01E0);

        // Saturation, positive then negative, then an in-range mixed sum.
        applyStimulus(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 1'b1, 1'b0, "satpos.delay");
        applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, "satpos.sample");
        checkOutput("satpos.value", oFirOut, 16'h7FFF);
        applyStimulus(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 1'b1, 1'b0, "satneg.delay");
        applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, "satneg.sample");
        checkOutput("satneg.value", oFirOut, 16'h8000);
        applyStimulus(16'sd100, -16'sd50, -16'sd20, -16'sd40, 1'b1, 1'b0, "mixed.delay");
        applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, "mixed.sample");
        checkOutput("mixed.value", oFirOut, 16'hFFF6);

        // Bring the output back to 480, then reset between edges.
        applyStimulus(16'sd96, 16'sd112, 16'sd128, 16'sd144, 1'b1, 1'b0, "midrst.load");
        applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, "midrst.sample");
        checkOutput("midrst.before", oFirOut, 16'h01E0);
        iEnDelay      = 1'b0;
        iEnSample600k = 1'b0;
        #10;
        iRsn = 1'b0;
        #1;
        checkOutput("midrst.async.out",   oFirOut,            16'h0000);
        checkOutput("midrst.async.delay", dut.rFinalSumDelay, 16'h0000);
        #5;
        iRsn     = 1'b1;
        refDelay = 16'h0000;
        refOut   = 16'h0000;
        applyStimulus(16'sd500, 16'sd500, 16'sd500, 16'sd500, 1'b0, 1'b0, "midrst.after");

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(randSample(), randSample(), randSample(), randSample(),
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
